// File: rtl/c_fetch_hw_queue.sv
// c_fetch_hw_queue: halfword-granular RV32IC fetch queue presenting whole instructions with their PC
module c_fetch_hw_queue #(
  parameter int          DEPTH_HW = 8,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush_i,
  input  logic [31:0] flush_pc_i,
  input  logic        fetch_valid_i,
  output logic        fetch_ready_o,
  input  logic [31:0] fetch_word_i,
  output logic        inst_valid_o,
  input  logic        inst_ready_i,
  output logic [31:0] inst_o,
  output logic [31:0] inst_pc_o,
  output logic        inst_is_c_o
);
  localparam int AW = $clog2(DEPTH_HW);
  logic [15:0]   r_mem [DEPTH_HW];
  logic [AW-1:0] r_rd_ptr, r_wr_ptr;
  logic [AW:0]   r_count;
  logic [31:0]   r_pc;
  logic          r_drop_low;
  logic [15:0]   w_h0, w_h1;
  logic          w_is_c, w_push, w_pop;
  logic [1:0]    w_push_n, w_pop_n;
  assign w_h0          = r_mem[r_rd_ptr];
  assign w_h1          = r_mem[r_rd_ptr + AW'(1)];
  assign w_is_c        = w_h0[1:0] != 2'b11;
  assign fetch_ready_o = !reset && r_count <= (AW+1)'(DEPTH_HW - 2);
  assign inst_valid_o  = !reset && !flush_i && (w_is_c ? r_count >= (AW+1)'(1) : r_count >= (AW+1)'(2));
  assign inst_o        = inst_valid_o ? (w_is_c ? {16'h0, w_h0} : {w_h1, w_h0}) : 32'h0000_0013;
  assign inst_is_c_o   = inst_valid_o && w_is_c;
  assign inst_pc_o     = r_pc;
  assign w_push        = fetch_valid_i && fetch_ready_o && !flush_i;
  assign w_pop         = inst_valid_o && inst_ready_i;
  assign w_push_n      = w_push ? (r_drop_low ? 2'd1 : 2'd2) : 2'd0;
  assign w_pop_n       = w_pop ? (w_is_c ? 2'd1 : 2'd2) : 2'd0;
  // halfword storage: upper half only when the redirect target was halfword-aligned
  always_ff @(posedge clk) begin
    if (w_push && r_drop_low) r_mem[r_wr_ptr] <= fetch_word_i[31:16];
    else if (w_push) begin
      r_mem[r_wr_ptr]          <= fetch_word_i[15:0];
      r_mem[r_wr_ptr + AW'(1)] <= fetch_word_i[31:16];
    end
  end
  // pointers, occupancy and head PC; flush discards everything and retargets the PC
  always_ff @(posedge clk) begin
    if (reset) begin
      r_count    <= '0;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_pc       <= RESET_PC & ~32'h1;
      r_drop_low <= RESET_PC[1];
    end else if (flush_i) begin
      r_count    <= '0;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_pc       <= flush_pc_i & ~32'h1;
      r_drop_low <= flush_pc_i[1];
    end else begin
      r_count  <= r_count + (AW+1)'(w_push_n) - (AW+1)'(w_pop_n);
      r_rd_ptr <= r_rd_ptr + AW'(w_pop_n);
      r_wr_ptr <= r_wr_ptr + AW'(w_push_n);
      r_pc     <= r_pc + {29'h0, w_pop_n, 1'b0};
      if (w_push) r_drop_low <= 1'b0;
    end
  end
endmodule
